// File: rtl/assoc_mem_dist_accum_if.sv
// Interface bundling the control, streaming and result signals of
// assoc_mem_dist_accum.
//   master : the chunk source / result consumer (drives start, num_classes,
//            query_chunk, class_chunk, in_valid)
//   slave  : the accumulator (drives in_ready, chunk_idx, class_idx, busy,
//            dist_valid, dist_regs)
interface assoc_mem_dist_accum_if #(
  parameter int unsigned ChunkWidth = 128,
  parameter int unsigned NumChunks  = 4,
  parameter int unsigned NumClasses = 32,
  parameter int unsigned DistWidth  = 16
);
  localparam int unsigned ClsW = (NumClasses > 1) ? $clog2(NumClasses) : 1;
  localparam int unsigned NumW = $clog2(NumClasses) + 1;
  localparam int unsigned ChkW = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  logic                                   start;
  logic [NumW-1:0]                        num_classes;
  logic [ChunkWidth-1:0]                  query_chunk;
  logic [ChunkWidth-1:0]                  class_chunk;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [ChkW-1:0]                        chunk_idx;
  logic [ClsW-1:0]                        class_idx;
  logic                                   busy;
  logic                                   dist_valid;
  logic [NumClasses-1:0][DistWidth-1:0]   dist_regs;

  modport master (
    output start, num_classes, query_chunk, class_chunk, in_valid,
    input  in_ready, chunk_idx, class_idx, busy, dist_valid, dist_regs
  );

  modport slave (
    input  start, num_classes, query_chunk, class_chunk, in_valid,
    output in_ready, chunk_idx, class_idx, busy, dist_valid, dist_regs
  );
endinterface

// File: rtl/assoc_mem_dist_accum.sv
// Streaming Hamming-distance accumulator feeding the associative-memory
// min-search tree. For every accepted chunk pair it adds
// popcount(query ^ class) to a running sum; on the last chunk of a class the
// sum is written to that class's distance register.
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high
//   bus    : assoc_mem_dist_accum_if.slave (start/num_classes control, chunk
//            stream with valid/ready, chunk/class index hints, busy,
//            dist_valid and the packed distance array)
//
// Build option: define ASSOC_DIST_POPCNT_PIPE_EN to register the popcount
// (plus last-chunk / class tags) before the accumulator. This adds the DRAIN
// state and one cycle of result latency; throughput is unchanged.
module assoc_mem_dist_accum #(
  parameter int unsigned ChunkWidth = 128,
  parameter int unsigned NumChunks  = 4,
  parameter int unsigned NumClasses = 32,
  parameter int unsigned DistWidth  = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  assoc_mem_dist_accum_if.slave bus
);
  localparam int unsigned ClsW = (NumClasses > 1) ? $clog2(NumClasses) : 1;
  localparam int unsigned NumW = $clog2(NumClasses) + 1;
  localparam int unsigned ChkW = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [NumW-1:0]                      n_cls;
  logic [NumW-1:0]                      n_cls_clamped;
  logic [ChkW-1:0]                      chunk_idx;
  logic [ClsW-1:0]                      class_idx;
  logic [DistWidth-1:0]                 acc;
  logic [NumClasses-1:0][DistWidth-1:0] dist_regs;
  logic                                 dist_valid;

  logic                 start_ok;
  logic                 xfer;
  logic                 last_chunk;
  logic                 last_class;
  logic [DistWidth-1:0] pop;

`ifdef ASSOC_DIST_POPCNT_PIPE_EN
  logic                 pipe_valid;
  logic [DistWidth-1:0] pipe_pop;
  logic                 pipe_last;
  logic [ClsW-1:0]      pipe_cls;
`endif

  function automatic logic [DistWidth-1:0] popcount(input logic [ChunkWidth-1:0] v);
    logic [DistWidth-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < ChunkWidth; i++) begin
      cnt = cnt + DistWidth'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    start_ok   = bus.start && ((state == IDLE) || (state == DONE));
    xfer       = bus.in_valid && (state == RUN);
    pop        = popcount(bus.query_chunk ^ bus.class_chunk);
    last_chunk = (chunk_idx == ChkW'(NumChunks - 1));
    last_class = ({1'b0, class_idx} == (n_cls - NumW'(1)));
    if ((bus.num_classes == '0) || (bus.num_classes > NumW'(NumClasses))) begin
      n_cls_clamped = NumW'(NumClasses);
    end else begin
      n_cls_clamped = bus.num_classes;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (xfer && last_chunk && last_class) begin
`ifdef ASSOC_DIST_POPCNT_PIPE_EN
          state_next = DRAIN;
`else
          state_next = DONE;
`endif
        end
      end
      DRAIN: begin
        bus.busy   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (bus.start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_cls      <= NumW'(NumClasses);
      chunk_idx  <= '0;
      class_idx  <= '0;
      acc        <= '0;
      dist_regs  <= '1;
      dist_valid <= 1'b0;
`ifdef ASSOC_DIST_POPCNT_PIPE_EN
      pipe_valid <= 1'b0;
      pipe_pop   <= '0;
      pipe_last  <= 1'b0;
      pipe_cls   <= '0;
`endif
    end else begin
      // Valid lags entry into DONE by one edge and drops on the start edge.
      dist_valid <= (state == DONE) && !bus.start;

      if (start_ok) begin
        n_cls     <= n_cls_clamped;
        chunk_idx <= '0;
        class_idx <= '0;
        acc       <= '0;
        dist_regs <= '1;
`ifdef ASSOC_DIST_POPCNT_PIPE_EN
        pipe_valid <= 1'b0;
`endif
      end else begin
        // Stream position advances at the handshake in both builds.
        if (xfer) begin
          if (last_chunk) begin
            chunk_idx <= '0;
            class_idx <= class_idx + ClsW'(1);
          end else begin
            chunk_idx <= chunk_idx + ChkW'(1);
          end
        end

`ifdef ASSOC_DIST_POPCNT_PIPE_EN
        // Accumulate from the registered popcount one cycle behind the
        // handshake; the tags carried with it select the destination.
        pipe_valid <= xfer;
        if (xfer) begin
          pipe_pop  <= pop;
          pipe_last <= last_chunk;
          pipe_cls  <= class_idx;
        end
        if (pipe_valid) begin
          if (pipe_last) begin
            dist_regs[pipe_cls] <= acc + pipe_pop;
            acc                 <= '0;
          end else begin
            acc <= acc + pipe_pop;
          end
        end
`else
        if (xfer) begin
          if (last_chunk) begin
            dist_regs[class_idx] <= acc + pop;
            acc                  <= '0;
          end else begin
            acc <= acc + pop;
          end
        end
`endif
      end
    end
  end

  assign bus.chunk_idx  = chunk_idx;
  assign bus.class_idx  = class_idx;
  assign bus.dist_valid = dist_valid;
  assign bus.dist_regs  = dist_regs;

endmodule

// File: tb/tb_assoc_mem_dist_accum.sv
// Scoreboard bench for assoc_mem_dist_accum: each run pushes the expected
// distance array; a monitor pops and compares on each dist_valid rise and
// also checks the latency from the last transfer.
module tb_assoc_mem_dist_accum;
  localparam int CW  = 128;
  localparam int NCH = 4;
  localparam int NCL = 32;
  localparam int DW  = 16;
`ifdef ASSOC_DIST_POPCNT_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  assoc_mem_dist_accum_if #(.ChunkWidth(CW), .NumChunks(NCH), .NumClasses(NCL), .DistWidth(DW)) bus ();

  assoc_mem_dist_accum #(.ChunkWidth(CW), .NumChunks(NCH), .NumClasses(NCL), .DistWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [NCL*DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mask(input int n);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] q_chunk(input int c);
    return {32'hDEADBEEF ^ 32'(c), 32'h13579BDF, 32'hF0F00F0F, 32'(c)};
  endfunction

  // mode 0: class == query; 1: class k differs in k bits of chunk 0;
  // 2: class == ~query; 3: class k differs in (k%5)+c bits of chunk c.
  function automatic logic [CW-1:0] c_chunk(input int mode, input int k, input int c);
    logic [CW-1:0] q;
    q = q_chunk(c);
    case (mode)
      0: return q;
      1: return (c == 0) ? (q ^ mask(k)) : q;
      2: return ~q;
      default: return q ^ mask((k % 5) + c);
    endcase
  endfunction

  function automatic logic [NCL*DW-1:0] build_exp(input int mode, input int n);
    logic [NCL*DW-1:0] v;
    logic [DW-1:0] d;
    for (int k = 0; k < NCL; k++) begin
      case (mode)
        0: d = 16'd0;
        1: d = 16'(k);
        2: d = 16'd512;
        default: d = 16'(4 * (k % 5) + 6);
      endcase
      v[k*DW +: DW] = (k < n) ? d : 16'hFFFF;
    end
    return v;
  endfunction

  // Monitor: transfer tracking and result comparison at the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   last_t = 0;
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    logic [NCL*DW-1:0] e;
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) last_t = cyc + 1;
      if (bus.dist_valid && !prev_dv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dist_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < NCL; i++)
            check($sformatf("dist[%0d]", i), 64'(bus.dist_regs[i]), 64'(e[i*DW +: DW]));
          check("latency", 64'(cyc - last_t), 64'(EXP_LAT));
        end
      end
      prev_dv = bus.dist_valid;
    end
  end

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < NCL; i++)
      check($sformatf("%s_dist[%0d]", tag, i), 64'(bus.dist_regs[i]), 64'hFFFF);
    check({tag, "_dist_valid"}, 64'(bus.dist_valid), 64'd0);
    check({tag, "_in_ready"},   64'(bus.in_ready),   64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_chunk_idx"},  64'(bus.chunk_idx),  64'd0);
    check({tag, "_class_idx"},  64'(bus.class_idx),  64'd0);
  endtask

  // Entered and left at posedge+1.
  task automatic start_run(input int ncls_in);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.num_classes = 6'(ncls_in);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic stream(input int mode, input int total, input bit stall,
                        input int abort_after, input int poke_at, input bit check_idx);
    int k = 0;
    int n = 0;
    bit hs;
    bit tog = 1'b0;
    while (k < total && n < 2000) begin
      if (abort_after >= 0 && k == abort_after) break;
      bus.query_chunk = q_chunk(k % NCH);
      bus.class_chunk = c_chunk(mode, k / NCH, k % NCH);
      bus.in_valid    = stall ? tog : 1'b1;
      tog             = !tog;
      bus.start       = (k == poke_at);
      bus.num_classes = (k == poke_at) ? 6'd2 : 6'd0;
      if (check_idx && bus.in_valid) begin
        check("chunk_idx", 64'(bus.chunk_idx), 64'(k % NCH));
        check("class_idx", 64'(bus.class_idx), 64'(k / NCH));
        check("in_ready_run", 64'(bus.in_ready), 64'd1);
      end
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      n++;
      if (hs) k++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (abort_after < 0) check("stream_complete", 64'(k), 64'(total));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check({tag, "_result_seen"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_dist_valid"},  64'(bus.dist_valid), 64'd1);
    check({tag, "_busy_done"},   64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.num_classes = '0;
    bus.query_chunk = '0;
    bus.class_chunk = '0;
    bus.in_valid    = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Identical vectors, all 32 classes, back-to-back.
    start_run(32);
    exp_q.push_back(build_exp(0, 32));
    stream(0, 128, 1'b0, -1, -1, 1'b0);
    drain("identical");

    // Distinct distances in chunk 0, valid toggling, index sequence checked.
    start_run(32);
    exp_q.push_back(build_exp(1, 32));
    stream(1, 128, 1'b1, -1, -1, 1'b1);
    drain("distinct");

    // Three classes, fully inverted.
    start_run(3);
    exp_q.push_back(build_exp(2, 3));
    stream(2, 12, 1'b0, -1, -1, 1'b0);
    check("in_ready_after_12", 64'(bus.in_ready), 64'd0);
    drain("partial");

    // num_classes=0 clamps to 32; start pulse mid-RUN ignored.
    start_run(0);
    exp_q.push_back(build_exp(3, 32));
    stream(3, 128, 1'b0, -1, 40, 1'b0);
    drain("clamp");

    // Reset after 5 transfers, then a fresh short run.
    start_run(32);
    stream(1, 128, 1'b0, 5, -1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    start_run(4);
    exp_q.push_back(build_exp(1, 4));
    stream(1, 16, 1'b0, -1, -1, 1'b1);
    drain("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
